// File: rtl/sequence_frame_sender.sv
`default_nettype none
// sequence_frame_sender: accepts 4-word frames into a one-deep pending buffer and
// serialises them word0..word3 aligned to a free-running 4-slot phase counter.
module sequence_frame_sender #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4*DW-1:0] s_data,
  output logic [DW-1:0]   outp,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic [1:0]      phase,
  output logic [15:0]     frames_sent
);

  logic [1:0]      phase_q;
  logic            pend_full_q;
  logic            pend_full_d;
  logic [4*DW-1:0] pend_q;
  logic [3*DW-1:0] shift_q;
  logic [DW-1:0]   outp_q;
  logic            valid_q;
  logic            first_q;
  logic            last_q;
  logic            ready_q;
  logic [15:0]     frames_q;
  logic            accept;
  logic            load;

  // ready_q mirrors the empty state of the pending buffer, so accept and load are exclusive
  assign accept = s_valid & ready_q;
  assign load   = (phase_q == 2'd3) & pend_full_q;

  always_comb begin
    pend_full_d = pend_full_q;
    if (load) begin
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= 2'd0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      shift_q     <= '0;
      outp_q      <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      ready_q     <= 1'b0;
      frames_q    <= 16'd0;
    end else begin
      phase_q     <= phase_q + 2'd1;
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      if (accept) begin
        pend_q <= s_data;
      end
      if (last_q) begin
        frames_q <= frames_q + 16'd1;
      end
      if (load) begin
        outp_q  <= pend_q[DW-1:0];
        shift_q <= pend_q[4*DW-1:DW];
        valid_q <= 1'b1;
        first_q <= 1'b1;
        last_q  <= 1'b0;
      end else if (valid_q && (phase_q != 2'd3)) begin
        // mid-frame: next slot carries word phase_q+1
        outp_q  <= shift_q[DW-1:0];
        shift_q <= shift_q >> DW;
        first_q <= 1'b0;
        last_q  <= (phase_q == 2'd2);
      end else begin
        outp_q  <= '0;
        valid_q <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign s_ready     = ready_q;
  assign outp        = outp_q;
  assign out_valid   = valid_q;
  assign out_first   = first_q;
  assign out_last    = last_q;
  assign phase       = phase_q;
  assign frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_frame_sender.sv
`default_nettype none
// tb_sequence_frame_sender: directed and random stimulus against a slot-level
// reference model of frame acceptance and phase-aligned serialisation.
module tb_sequence_frame_sender;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic [4*DW-1:0] s_data = '0;
  logic            s_ready;
  logic [DW-1:0]   outp;
  logic            out_valid;
  logic            out_first;
  logic            out_last;
  logic [1:0]      phase;
  logic [15:0]     frames_sent;

  sequence_frame_sender #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .outp(outp), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .phase(phase), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: slot number, pending frame, frame currently on the wire.
  int              m_phase = 0;
  bit              m_pend = 0, m_act = 0, m_ready = 0, m_acc = 0;
  logic [4*DW-1:0] m_pdata = '0, m_frame = '0;
  logic [15:0]     m_sent = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_phase = 0; m_pend = 0; m_act = 0; m_ready = 0; m_acc = 0; m_sent = '0;
    end else begin
      m_acc = s_valid && m_ready;
      if (m_act && m_phase == 3) begin
        m_sent++;
        m_act = 0;
      end
      if (m_phase == 3 && m_pend) begin
        m_act = 1; m_frame = m_pdata; m_pend = 0;
      end
      if (m_acc) begin
        m_pend = 1; m_pdata = s_data;
      end
      m_phase = (m_phase + 1) % 4;
      m_ready = !m_pend;
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] ew;
    ew = m_act ? m_frame[m_phase*DW +: DW] : '0;
    chk("phase",       32'(phase),       32'(m_phase));
    chk("outp",        32'(outp),        32'(ew));
    chk("out_valid",   32'(out_valid),   32'(m_act));
    chk("out_first",   32'(out_first),   32'(m_act && m_phase == 0));
    chk("out_last",    32'(out_last),    32'(m_act && m_phase == 3));
    chk("s_ready",     32'(s_ready),     32'(m_ready));
    chk("frames_sent", 32'(frames_sent), 32'(m_sent));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Hold an offered frame until it is taken, then maybe offer a fresh one.
  task automatic drive_random(input int pct);
    if (!s_valid || m_acc) begin
      s_valid = ($urandom_range(0, 99) < pct);
      s_data  = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   first_cyc;
    int   lat;
    bit   seen;
    int   nf;
    int   run;
    int   maxrun;
    int   total;
    int   vcount;
    logic [15:0] base;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();

    // Single frame offered in cycle 0 after release
    rst_n = 1'b1; s_valid = 1'b1; s_data = 32'h04030201;
    first_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (m_acc) s_valid = 1'b0;
      if (out_first && first_cyc < 0) first_cyc = c;
    end
    chk("single_first_cycle", 32'(first_cyc), 32'd4);
    chk("single_frames_sent", 32'(frames_sent), 32'd1);

    // Accept in a phase-3 slot: word0 four cycles later
    for (int i = 0; i < 8 && !(m_phase == 3 && m_ready && !m_act); i++) tick();
    chk("align_setup", 32'(m_phase == 3 && m_ready && !m_act), 32'd1);
    s_valid = 1'b1; s_data = 32'hDDCCBBAA;
    tick();
    s_valid = 1'b0;
    lat = 0; seen = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (out_first && !seen) begin lat = i; seen = 1; end
    end
    chk("align_latency", 32'(lat), 32'd4);
    repeat (2) tick();

    // Throughput: eight frames back to back with backpressure on each
    base = m_sent; nf = 0; run = 0; maxrun = 0; total = 0;
    s_valid = 1'b1; s_data = $urandom;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (m_acc) begin
        nf++;
        if (nf < 8) s_data = $urandom;
        else s_valid = 1'b0;
      end
      if (out_valid) begin
        total++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("tput_valid_cycles", 32'(total), 32'd32);
    chk("tput_max_run", 32'(maxrun), 32'd32);
    chk("tput_frames", 32'(frames_sent), 32'(base + 16'd8));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_random(60);
      tick();
    end
    s_valid = 1'b0;
    repeat (10) tick();

    // Reset during word2 with a second frame pending
    seen = 0;
    s_valid = 1'b1; s_data = $urandom;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (m_acc) s_data = $urandom;
      if (m_act && m_phase == 2 && m_pend) seen = 1;
    end
    chk("rst_setup", 32'(seen), 32'd1);
    rst_n = 1'b0; s_valid = 1'b0;
    tick();
    chk("rst_outp", 32'(outp), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("rst_no_resume", 32'(vcount), 32'd0);

    // frames_sent wrap
    force dut.frames_q = 16'hFFFF;
    m_sent = 16'hFFFF;
    tick();
    release dut.frames_q;
    tick();
    s_valid = 1'b1; s_data = 32'h11223344;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_acc) s_valid = 1'b0;
    end
    chk("wrap_frames", 32'(frames_sent), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
